// File: rtl/perceptron_train_ctrl.sv
// Perceptron training-loop sequencer: walks the samples, requests a MAC sum,
// applies the step activation and strobes a weight update on each error.
// Repeats epochs until an error-free epoch or the epoch limit is reached.
// Ports: clk, rst_n (async, active-low), start, abort, sample_idx, y_target,
//        mac_req/mac_ack/mac_sum (MAC handshake), upd_en/upd_sign (weight
//        update), busy, done, converged, epoch, err_count, timeout_err.
// Optional macro PTC_ACK_TIMEOUT_EN: abort a run if mac_ack does not arrive
// within ACK_TIMEOUT request cycles.
module perceptron_train_ctrl #(
    parameter int N_SAMPLES   = 3,
    parameter int SUM_W       = 16,
    parameter int MAX_EPOCHS  = 15,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic [$clog2(N_SAMPLES)-1:0] sample_idx,
    input  logic                         y_target,
    output logic                         mac_req,
    input  logic                         mac_ack,
    input  logic [SUM_W-1:0]             mac_sum,
    output logic                         upd_en,
    output logic                         upd_sign,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic [7:0]                   epoch,
    output logic [7:0]                   err_count,
    output logic                         timeout_err
);

    localparam int IW = $clog2(N_SAMPLES);

    if (N_SAMPLES < 2 || MAX_EPOCHS < 1 || MAX_EPOCHS > 255 ||
        ACK_TIMEOUT < 1) begin : g_bad_cfg
        $error("perceptron_train_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_EVAL,
        S_UPDATE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      epoch_q, epoch_d;
    logic [7:0]      err_q, err_d;
    logic            conv_q, conv_d;
    logic            eflag_q, eflag_d;
    logic            act_q, act_d;
    logic            sum_pos;

    // Step activation: strictly positive signed sum.
    assign sum_pos = !mac_sum[SUM_W-1] && (mac_sum != '0);

`ifdef PTC_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tout_q, tout_d;
    logic            tout_hit;

    // Counts REQ cycles without ack; zero outside REQ so every entry restarts.
    assign tout_hit = (state_q == S_REQ) && !mac_ack &&
                      (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_REQ && !mac_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    always_comb begin
        tout_d = tout_q;
        if (state_q == S_IDLE && start) begin
            tout_d = 1'b0;
        end else if (tout_hit && !abort) begin
            tout_d = 1'b1;
        end
    end

    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        conv_d  = conv_q;
        eflag_d = eflag_q;
        act_d   = act_q;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_REQ;
                        idx_d   = '0;
                        epoch_d = '0;
                        err_d   = '0;
                        conv_d  = 1'b0;
                        eflag_d = 1'b0;
                    end
                end
                S_REQ: begin
                    if (mac_ack) begin
                        act_d   = sum_pos;
                        state_d = S_EVAL;
                    end
`ifdef PTC_ACK_TIMEOUT_EN
                    else if (tout_hit) begin
                        conv_d  = 1'b0;
                        state_d = S_FINISH;
                    end
`endif
                end
                S_EVAL: begin
                    if (act_q == y_target) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_UPDATE;
                        eflag_d = 1'b1;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end
                S_UPDATE: begin
                    state_d = S_NEXT;
                end
                S_NEXT: begin
                    if (idx_q != IW'(N_SAMPLES - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_REQ;
                    end else if (!eflag_q) begin
                        conv_d  = 1'b1;
                        state_d = S_FINISH;
                    end else if (epoch_q == 8'(MAX_EPOCHS - 1)) begin
                        conv_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        epoch_d = epoch_q + 8'd1;
                        idx_d   = '0;
                        eflag_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            epoch_q <= '0;
            err_q   <= '0;
            conv_q  <= 1'b0;
            eflag_q <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            eflag_q <= eflag_d;
            act_q   <= act_d;
        end
    end

    // Strobes decode straight from the state flop so reset drops them at once.
    assign mac_req    = (state_q == S_REQ);
    assign upd_en     = (state_q == S_UPDATE);
    assign upd_sign   = (state_q == S_UPDATE) && y_target;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign sample_idx = idx_q;
    assign epoch      = epoch_q;
    assign err_count  = err_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl: directed scenarios plus
// randomized runs compared against an epoch/sample-level reference model.
module tb_perceptron_train_ctrl;

    localparam int NS   = 3;
    localparam int MAXE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  sample_idx;
    logic        y_target;
    logic        mac_req;
    logic        mac_ack;
    logic [15:0] mac_sum;
    logic        upd_en;
    logic        upd_sign;
    logic        busy;
    logic        done;
    logic        converged;
    logic [7:0]  epoch;
    logic [7:0]  err_count;
    logic        timeout_err;

    logic signed [15:0] sum_tab [MAXE][NS];
    int                 dly_tab [MAXE][NS];
    bit                 lab [NS];
    bit                 ack_en;
    int                 wcnt;

    int n_chk  = 0;
    int n_pass = 0;

    bit exp_sign [$];
    int exp_idx  [$];
    bit got_sign [$];
    int got_idx  [$];
    int maxrun;
    bit unstable;

    perceptron_train_ctrl #(
        .N_SAMPLES  (NS),
        .SUM_W      (16),
        .MAX_EPOCHS (MAXE),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .sample_idx (sample_idx),
        .y_target   (y_target),
        .mac_req    (mac_req),
        .mac_ack    (mac_ack),
        .mac_sum    (mac_sum),
        .upd_en     (upd_en),
        .upd_sign   (upd_sign),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .epoch      (epoch),
        .err_count  (err_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Sample store and MAC stand-in.
    assign y_target = lab[int'(sample_idx)];
    assign mac_sum  = sum_tab[int'(epoch[1:0])][int'(sample_idx)];
    assign mac_ack  = ack_en && mac_req &&
                      (wcnt >= dly_tab[int'(epoch[1:0])][int'(sample_idx)]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else        wcnt <= (mac_req && !mac_ack) ? wcnt + 1 : 0;
    end

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic set_tab(input int s0, input int s1, input int s2,
                           input bit l0, input bit l1, input bit l2);
        for (int k = 0; k < MAXE; k++) begin
            sum_tab[k][0] = 16'(s0);
            sum_tab[k][1] = 16'(s1);
            sum_tab[k][2] = 16'(s2);
            for (int s = 0; s < NS; s++) dly_tab[k][s] = 0;
        end
        lab[0] = l0;
        lab[1] = l1;
        lab[2] = l2;
    endtask

    // Reference: replay the training rules epoch by epoch.
    function automatic void model(output int cyc, output int ep,
                                  output int errs, output bit conv);
        bit e;
        bit act;
        cyc  = 0;
        errs = 0;
        conv = 0;
        ep   = 0;
        exp_sign.delete();
        exp_idx.delete();
        for (int k = 0; k < MAXE; k++) begin
            e  = 0;
            ep = k;
            for (int s = 0; s < NS; s++) begin
                act = (sum_tab[k][s] > 0);
                cyc += dly_tab[k][s] + 3;
                if (act != lab[s]) begin
                    cyc++;
                    errs++;
                    e = 1;
                    exp_sign.push_back(lab[s]);
                    exp_idx.push_back(s);
                end
            end
            if (!e) begin
                conv = 1;
                break;
            end
        end
        cyc += 1;
    endfunction

    // Pulse start, then watch outputs once per cycle until done or budget.
    task automatic run_train(input int budget, input int glitch,
                             output int cyc, output bit got);
        int run;
        int pidx;
        got_sign.delete();
        got_idx.delete();
        maxrun   = 0;
        unstable = 0;
        run      = 0;
        pidx     = 0;
        cyc      = 0;
        got      = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            start = (i == glitch);
            if (busy) cyc++;
            if (upd_en) begin
                got_sign.push_back(upd_sign);
                got_idx.push_back(int'(sample_idx));
            end
            if (mac_req) begin
                if (run > 0 && int'(sample_idx) != pidx) unstable = 1;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            pidx = int'(sample_idx);
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int glitch);
        int ecyc, eep, eerr, cyc;
        bit econv, got;
        int n;
        model(ecyc, eep, eerr, econv);
        run_train(300, glitch, cyc, got);
        chk({tag, ".done"}, got, 1);
        chk({tag, ".cycles"}, cyc, ecyc);
        chk({tag, ".conv"}, converged, econv);
        chk({tag, ".epoch"}, epoch, eep);
        chk({tag, ".errs"}, err_count, eerr);
        chk({tag, ".nupd"}, got_sign.size(), exp_sign.size());
        n = (got_sign.size() < exp_sign.size()) ? got_sign.size()
                                                : exp_sign.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".sign"}, got_sign[i], exp_sign[i]);
            chk({tag, ".uidx"}, got_idx[i], exp_idx[i]);
        end
        @(posedge clk);
        #1;
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".done_low"}, done, 0);
    endtask

    initial begin
        int cyc;
        bit got;
        bit seen;
        int nd;

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ack_en = 1'b1;
        set_tab(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.req", mac_req, 0);
        chk("rst.upd", upd_en, 0);
        chk("rst.sign", upd_sign, 0);
        chk("rst.idx", sample_idx, 0);
        chk("rst.epoch", epoch, 0);
        chk("rst.err", err_count, 0);
        chk("rst.conv", converged, 0);
        chk("rst.tout", timeout_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_tab(-5, 7, 3, 0, 1, 1);
        check_run("clean", 0);

        set_tab(-5, 7, 3, 0, 1, 1);
        sum_tab[0][1] = -16'sd2;
        check_run("one_err", 0);

        set_tab(4, -3, -9, 0, 1, 1);
        check_run("maxep", 0);

        set_tab(-5, 7, 3, 0, 1, 1);
        dly_tab[0][2] = 5;
        check_run("delay", 4);
        chk("delay.req_len", maxrun, 6);
        chk("delay.idx_stable", unstable, 0);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < MAXE; k++) begin
                for (int s = 0; s < NS; s++) begin
                    sum_tab[k][s] = 16'($urandom_range(20) - 10);
                    dly_tab[k][s] = $urandom_range(2);
                end
            end
            for (int s = 0; s < NS; s++) lab[s] = 1'($urandom_range(1));
            check_run($sformatf("rnd%0d", r), 0);
        end

        set_tab(4, -3, -9, 0, 1, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            if (upd_en) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("arst.upd_seen", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.upd", upd_en, 0);
        chk("arst.busy", busy, 0);
        chk("arst.req", mac_req, 0);
        chk("arst.err", err_count, 0);
        chk("arst.epoch", epoch, 0);
        chk("arst.idx", sample_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_tab(4, -3, -9, 0, 1, 1);
        dly_tab[0][0] = 5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort.req", mac_req, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.req_low", mac_req, 0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) nd++;
            @(posedge clk);
            #1;
        end
        chk("abort.no_done", nd, 0);
        chk("abort.err_hold", err_count, 0);

        set_tab(-5, 7, 3, 0, 1, 1);
        ack_en = 1'b0;
        run_train(40, 0, cyc, got);
`ifdef PTC_ACK_TIMEOUT_EN
        chk("tout.done", got, 1);
        chk("tout.cycles", cyc, 17);
        chk("tout.flag", timeout_err, 1);
        chk("tout.conv", converged, 0);
`else
        chk("noack.done", got, 0);
        chk("noack.busy", busy, 1);
        chk("noack.req", mac_req, 1);
        chk("noack.tout", timeout_err, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("noack.abort", busy, 0);
`endif
        ack_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
